vga_sync_gen: RTL
=================

// Module: vga_sync_gen
// PURPOSE
//  Timing decoder directly downstream of the pixel counter on the 25 MHz pixel clock.
//  Consumes horizontal (0..799) and vertical (0..448) and produces registered
//  hsync, vsync, display enable, visible pixel coordinates, line/frame strobes and a frame count.
//  Tracks the vertical phase with an FSM and flags any counter sequence that skips or jumps.
//  Feeds the pixel/colour generation stage.
// PARAMETERS
//  H_VISIBLE 640  visible pixels per line
//  H_FRONT   16   horizontal front porch, pixels
//  H_SYNC    96   hsync width, pixels
//  H_TOTAL   800  pixels per line; terminal horizontal count = H_TOTAL-1
//  V_VISIBLE 400  visible lines
//  V_FRONT   12   vertical front porch, lines
//  V_SYNC    2    vsync width, lines
//  V_TOTAL   449  lines per frame; terminal vertical count = V_TOTAL-1
//  HSYNC_POL 0    hsync active level
//  VSYNC_POL 1    vsync active level
// PORTS
//  clk25        in   1   25 MHz pixel clock
//  reset        in   1   asynchronous, active-low reset
//  horizontal   in   10  horizontal count from pixel counter
//  vertical     in   9   vertical count from pixel counter
//  hsync        out  1   horizontal sync, active level HSYNC_POL
//  vsync        out  1   vertical sync, active level VSYNC_POL
//  display_en   out  1   1 while the pixel is visible
//  pixel_x      out  10  visible column; 0 when display_en=0
//  pixel_y      out  9   visible row; 0 when display_en=0
//  line_start   out  1   1-cycle pulse, horizontal==0
//  frame_start  out  1   1-cycle pulse, horizontal==0 && vertical==0
//  frame_count  out  8   completed-frame counter, wraps 255->0
//  seq_error    out  1   sticky; counter sequence violated
// BEHAVIOUR
//  - Reset (reset=0, async): hsync=~HSYNC_POL, vsync=~VSYNC_POL; display_en, pixel_x, pixel_y, strobes,
//    frame_count, seq_error=0; FSM=V_ACTIVE; seq_armed=0. Reset mid-frame aborts immediately.
//  - Latency: every output is registered exactly 1 clk25 after the input pair it describes.
//  - hsync active when H_VISIBLE+H_FRONT <= horizontal < H_VISIBLE+H_FRONT+H_SYNC (656..751).
//  - display_en = (horizontal<H_VISIBLE) && (FSM==V_ACTIVE); pixel_x/y = horizontal/vertical then.
//  - FSM V_ACTIVE->V_FRONT->V_SYNC->V_BACK->V_ACTIVE. Evaluated only when horizontal==H_TOTAL-1
//    (line end), using the line number about to begin, vertical+1 (0 after V_TOTAL-1).
//    Entry lines: V_FRONT at 400, V_SYNC at 412, V_BACK at 414, V_ACTIVE at 0.
//    vsync active in V_SYNC (lines 412..413).
//  - frame_count increments with each frame_start pulse.
//    The first frame_start after reset leaves it at 0 (no completed frame yet).
//  - Sequence check: keep previous inputs. Expected next pair:
//      h+1 on the same line;
//      h=0 with v+1 after h=799;
//      h=0, v=0 after (799,448).
//    Any mismatch sets seq_error (cleared only by reset).
//  - Sequence check arms one cycle after reset releases; the first sample is never checked.
//  - Out-of-range inputs (h>799 or v>448): seq_error=1, display_en=0, hsync/vsync inactive;
//    the FSM holds its state.
//  - Arithmetic: comparisons unsigned at input width; the next-line value wraps mod V_TOTAL.
// STRUCTURE
//  - Shared package vga_timing_pkg: H_*/V_* defaults and vphase_t enum
//    {V_ACTIVE, V_FRONT, V_SYNC, V_BACK}. The pixel counter reuses the same constants.
//  - One sub-module, vga_seq_checker: previous-sample registers, expected-next logic, sticky flag.
//  - Top holds the FSM, the sync/enable decode and the output registers.
// TESTING
//  - Reset held low, then released at (0,0) with the counter model running:
//    cycle 1 gives display_en=1, pixel_x=0, frame_start=1, hsync=1, vsync=0.
//  - Drive h=655,656,751,752 on line 0: hsync reads 1,0,0,1 one cycle later.
//  - Run a full frame: vsync=1 exactly for lines 412..413 (1600 clocks);
//    display_en=0 on lines 400..448; frame_count=1 at the second frame_start.
//  - 256 frames: frame_count wraps 255->0 with no seq_error.
//  - Inject h jump 300->302: seq_error=1 next cycle and stays 1; a later reset clears it.
//  - Assert reset at (500,200) mid-line: outputs return to reset values asynchronously;
//    after release at (0,0), normal timing resumes and seq_error=0.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x400 @ 25 MHz pixel clock) and the
// vertical phase encoding used by the sync decoder and the pixel counter.
package vga_timing_pkg;

  localparam logic [9:0] H_VISIBLE     = 10'd640;
  localparam logic [9:0] H_FRONT_PX    = 10'd16;
  localparam logic [9:0] H_SYNC_PX     = 10'd96;
  localparam logic [9:0] H_TOTAL       = 10'd800;
  localparam logic [9:0] H_LAST        = H_TOTAL - 10'd1;
  localparam logic [9:0] HSYNC_START   = H_VISIBLE + H_FRONT_PX;
  localparam logic [9:0] HSYNC_END     = HSYNC_START + H_SYNC_PX;

  localparam logic [8:0] V_VISIBLE     = 9'd400;
  localparam logic [8:0] V_FRONT_LINES = 9'd12;
  localparam logic [8:0] V_SYNC_LINES  = 9'd2;
  localparam logic [8:0] V_TOTAL       = 9'd449;
  localparam logic [8:0] V_LAST        = V_TOTAL - 9'd1;
  localparam logic [8:0] VSYNC_START   = V_VISIBLE + V_FRONT_LINES;
  localparam logic [8:0] VBACK_START   = VSYNC_START + V_SYNC_LINES;

  localparam logic HSYNC_POL = 1'b0;
  localparam logic VSYNC_POL = 1'b1;

  typedef enum logic [1:0] {
    V_ACTIVE,
    V_FRONT,
    V_SYNC,
    V_BACK
  } vphase_t;

  // Line number that follows v, wrapping after the last line of the frame.
  function automatic logic [8:0] next_line(input logic [8:0] v);
    return (v == V_LAST) ? 9'd0 : v + 9'd1;
  endfunction

endpackage

// File: rtl/vga_seq_checker.sv
// Watches the incoming (horizontal, vertical) pair and raises a sticky flag
// as soon as the counter skips, repeats or leaves the legal range.
module vga_seq_checker
  import vga_timing_pkg::*;
(
  input  logic       clk25,
  input  logic       reset,
  input  logic [9:0] horizontal,
  input  logic [8:0] vertical,
  output logic       seq_error
);

  logic [9:0] prev_h_q, prev_h_d;
  logic [8:0] prev_v_q, prev_v_d;
  logic       armed_q, armed_d;
  logic       err_q, err_d;
  logic [9:0] exp_h;
  logic [8:0] exp_v;
  logic       in_range;

  // Predict the next pair from the previous one and fold any mismatch into the sticky flag.
  always_comb begin
    in_range = (horizontal <= H_LAST) && (vertical <= V_LAST);
    if (prev_h_q == H_LAST) begin
      exp_h = 10'd0;
      exp_v = next_line(prev_v_q);
    end else begin
      exp_h = prev_h_q + 10'd1;
      exp_v = prev_v_q;
    end
    prev_h_d = horizontal;
    prev_v_d = vertical;
    armed_d  = 1'b1;
    err_d    = err_q;
    if (!in_range) begin
      err_d = 1'b1;
    end else if (armed_q && ((horizontal != exp_h) || (vertical != exp_v))) begin
      err_d = 1'b1;
    end
  end

  // Previous-sample, arming and sticky-error registers; the first sample after reset only arms.
  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      prev_h_q <= 10'd0;
      prev_v_q <= 9'd0;
      armed_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      prev_h_q <= prev_h_d;
      prev_v_q <= prev_v_d;
      armed_q  <= armed_d;
      err_q    <= err_d;
    end
  end

  assign seq_error = err_q;

endmodule

// File: rtl/vga_sync_gen.sv
// Decodes the pixel counter into registered sync, enable, coordinate and
// strobe outputs, tracks the vertical phase and counts completed frames.
module vga_sync_gen
  import vga_timing_pkg::*;
(
  input  logic       clk25,
  input  logic       reset,
  input  logic [9:0] horizontal,
  input  logic [8:0] vertical,
  output logic       hsync,
  output logic       vsync,
  output logic       display_en,
  output logic [9:0] pixel_x,
  output logic [8:0] pixel_y,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic       seq_error
);

  vphase_t    state_q, state_d;
  logic [8:0] line_next;
  logic       in_range;

  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       display_en_q, display_en_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [8:0] pixel_y_q, pixel_y_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       frame_seen_q, frame_seen_d;

  // Vertical phase: advance at line end based on the line about to begin; hold on bad input.
  always_comb begin
    state_d   = state_q;
    in_range  = (horizontal <= H_LAST) && (vertical <= V_LAST);
    line_next = next_line(vertical);
    if (in_range && (horizontal == H_LAST)) begin
      case (state_q)
        V_ACTIVE: if (line_next == V_VISIBLE)   state_d = V_FRONT;
        V_FRONT:  if (line_next == VSYNC_START) state_d = V_SYNC;
        V_SYNC:   if (line_next == VBACK_START) state_d = V_BACK;
        V_BACK:   if (line_next == 9'd0)        state_d = V_ACTIVE;
        default:  state_d = V_ACTIVE;
      endcase
    end
  end

  // Sync/enable/coordinate decode and frame counting for the current input pair.
  always_comb begin
    hsync_d       = ~HSYNC_POL;
    vsync_d       = ~VSYNC_POL;
    if (in_range && (horizontal >= HSYNC_START) && (horizontal < HSYNC_END)) hsync_d = HSYNC_POL;
    if (in_range && (state_q == V_SYNC)) vsync_d = VSYNC_POL;
    display_en_d  = in_range && (horizontal < H_VISIBLE) && (state_q == V_ACTIVE);
    pixel_x_d     = display_en_d ? horizontal : 10'd0;
    pixel_y_d     = display_en_d ? vertical : 9'd0;
    line_start_d  = in_range && (horizontal == 10'd0);
    frame_start_d = line_start_d && (vertical == 9'd0);
    frame_count_d = frame_count_q;
    frame_seen_d  = frame_seen_q;
    if (frame_start_d) begin
      // The first frame start after reset opens a frame rather than completing one.
      if (frame_seen_q) frame_count_d = frame_count_q + 8'd1;
      frame_seen_d = 1'b1;
    end
  end

  // Phase register and output registers; reset aborts immediately.
  always_ff @(posedge clk25 or negedge reset) begin
    if (!reset) begin
      state_q       <= V_ACTIVE;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      display_en_q  <= 1'b0;
      pixel_x_q     <= 10'd0;
      pixel_y_q     <= 9'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
      frame_seen_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_en_q  <= display_en_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
      frame_seen_q  <= frame_seen_d;
    end
  end

  vga_seq_checker u_seq_checker (
    .clk25      (clk25),
    .reset      (reset),
    .horizontal (horizontal),
    .vertical   (vertical),
    .seq_error  (seq_error)
  );

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_en  = display_en_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule
